// File: rtl/pipe_hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit.
//   fwd_sel_e   : EX operand-select encoding (register file / EX-MEM / MEM-WB)
//   ex_rec_t    : in-flight record held for the EX stage
//   dst_rec_t   : in-flight record held for MEM and WB (destination only)
//   src_hit     : source-vs-stage dependency test
//   fwd_pick    : operand select, newest producer first
// Register indices are stored at RIDX_W bits, zero-extended from the
// instantiating module's index width, so NREG up to 2**RIDX_W is supported.
package pipe_hazard_unit_pkg;

  localparam int unsigned RIDX_W = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] ra;
    logic [RIDX_W-1:0] rb;
    logic              ra_used;
    logic              rb_used;
    logic [RIDX_W-1:0] rd;
    logic              wr;
    logic              ld;
  } ex_rec_t;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] rd;
    logic              wr;
  } dst_rec_t;

  function automatic logic src_hit(
    input logic              used,
    input logic [RIDX_W-1:0] idx,
    input logic              st_valid,
    input logic              st_wr,
    input logic [RIDX_W-1:0] st_rd,
    input logic              r0_zero
  );
    return used && st_valid && st_wr && (idx == st_rd) &&
           !(r0_zero && (idx == '0));
  endfunction

  function automatic fwd_sel_e fwd_pick(input logic hit_mem, input logic hit_wb);
    if (hit_mem)     return FWD_EXMEM;
    else if (hit_wb) return FWD_MEMWB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Saturating event counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   clr   : synchronous clear, wins over inc
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNTW'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: load-use / RAW stall, taken-branch flush, EX operand
// forwarding selects and saturating stall/flush event counters.
//   clk, rst            : clock, asynchronous active-low reset
//   id_*                : instruction currently in ID
//   ex_branch_taken     : branch in EX resolved taken
//   cnt_clr             : synchronous clear of both counters
//   stall, flush        : hold PC+IF/ID / squash IF/ID and ID/EX
//   fwd_a, fwd_b        : EX operand select (fwd_sel_e encoding)
//   stall_cnt, flush_cnt: saturating event counts
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned NREG    = 8,
  parameter bit          FWD_EN  = 1'b1,
  parameter bit          R0_ZERO = 1'b1,
  parameter int unsigned CNTW    = 16,
  localparam int unsigned RW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_ra,
  input  logic [RW-1:0]   id_rb,
  input  logic            id_ra_used,
  input  logic            id_rb_used,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            ex_branch_taken,
  input  logic            cnt_clr,
  output logic            stall,
  output logic            flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  ex_rec_t  id_rec;
  ex_rec_t  ex_r;
  dst_rec_t mem_r;
  dst_rec_t wb_r;

  logic a_ex, b_ex, a_mem, b_mem;
  logic load_use, raw_dep;
  logic fa_mem, fa_wb, fb_mem, fb_wb;

  always_comb begin
    id_rec         = '0;
    id_rec.valid   = id_valid;
    id_rec.ra      = RIDX_W'(id_ra);
    id_rec.rb      = RIDX_W'(id_rb);
    id_rec.ra_used = id_ra_used;
    id_rec.rb_used = id_rb_used;
    id_rec.rd      = RIDX_W'(id_rd);
    id_rec.wr      = id_regwrite;
    id_rec.ld      = id_memread;
  end

  // ID-source dependencies on older in-flight instructions
  assign a_ex  = src_hit(id_rec.ra_used, id_rec.ra, ex_r.valid,  ex_r.wr,  ex_r.rd,  R0_ZERO);
  assign b_ex  = src_hit(id_rec.rb_used, id_rec.rb, ex_r.valid,  ex_r.wr,  ex_r.rd,  R0_ZERO);
  assign a_mem = src_hit(id_rec.ra_used, id_rec.ra, mem_r.valid, mem_r.wr, mem_r.rd, R0_ZERO);
  assign b_mem = src_hit(id_rec.rb_used, id_rec.rb, mem_r.valid, mem_r.wr, mem_r.rd, R0_ZERO);

  assign load_use = id_valid && ex_r.ld && (a_ex || b_ex);
  // WB needs no stall: the register file writes through to ID reads
  assign raw_dep  = id_valid && (a_ex || b_ex || a_mem || b_mem);

  assign flush = ex_r.valid && ex_branch_taken;
  assign stall = !flush && (FWD_EN ? load_use : raw_dep);

  // EX-operand forwarding, from registered state only
  assign fa_mem = src_hit(ex_r.ra_used, ex_r.ra, mem_r.valid, mem_r.wr, mem_r.rd, R0_ZERO);
  assign fa_wb  = src_hit(ex_r.ra_used, ex_r.ra, wb_r.valid,  wb_r.wr,  wb_r.rd,  R0_ZERO);
  assign fb_mem = src_hit(ex_r.rb_used, ex_r.rb, mem_r.valid, mem_r.wr, mem_r.rd, R0_ZERO);
  assign fb_wb  = src_hit(ex_r.rb_used, ex_r.rb, wb_r.valid,  wb_r.wr,  wb_r.rd,  R0_ZERO);

  assign fwd_a = FWD_EN ? fwd_pick(fa_mem, fa_wb) : FWD_RF;
  assign fwd_b = FWD_EN ? fwd_pick(fb_mem, fb_wb) : FWD_RF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      wb_r        <= mem_r;
      mem_r.valid <= ex_r.valid;
      mem_r.rd    <= ex_r.rd;
      mem_r.wr    <= ex_r.wr;
      // bubble is a fully cleared record so it can never forward
      ex_r        <= (stall || flush) ? '0 : id_rec;
    end
  end

  sat_counter #(.CNTW(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit. Four instances share stimulus:
//   u0 default, u1 R0_ZERO=0, u2 FWD_EN=0, u3 CNTW=2.
// Each vector row names the instance whose outputs it checks.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_ra_used, id_rb_used, id_regwrite, id_memread;
  logic [2:0] id_ra, id_rb, id_rd;
  logic       ex_branch_taken, cnt_clr;

  logic        st0, st1, st2, st3, fl0, fl1, fl2, fl3;
  logic [1:0]  fa0, fa1, fa2, fa3, fb0, fb1, fb2, fb3;
  logic [15:0] sc0, sc1, sc2, fc0, fc1, fc2;
  logic [1:0]  sc3, fc3;

  pipe_hazard_unit u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .stall(st0), .flush(fl0), .fwd_a(fa0), .fwd_b(fb0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_hazard_unit #(.R0_ZERO(1'b0)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .stall(st1), .flush(fl1), .fwd_a(fa1), .fwd_b(fb1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_hazard_unit #(.FWD_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .stall(st2), .flush(fl2), .fwd_a(fa2), .fwd_b(fb2),
    .stall_cnt(sc2), .flush_cnt(fc2));

  pipe_hazard_unit #(.CNTW(2)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .stall(st3), .flush(fl3), .fwd_a(fa3), .fwd_b(fb3),
    .stall_cnt(sc3), .flush_cnt(fc3));

  typedef struct {
    bit       rs;                 // reset before this row
    int       sel;                // instance checked
    bit       v;
    bit [2:0] ra, rb;
    bit       rau, rbu;
    bit [2:0] rd;
    bit       rw, ld, br, clr;
    bit       es, ef;             // expected stall / flush
    bit [1:0] efa, efb;           // expected fwd_a / fwd_b
    bit       cc;                 // check counters on this row
    int       esc, efc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   nchecks = 0;
  int   nerr    = 0;

  function automatic vec_t mkv(input int rs, sel, v, ra, rb, rau, rbu, rd, rw, ld,
                               br, clr, es, ef, efa, efb, cc, esc, efc);
    vec_t t;
    t.rs = rs[0]; t.sel = sel; t.v = v[0]; t.ra = ra[2:0]; t.rb = rb[2:0];
    t.rau = rau[0]; t.rbu = rbu[0]; t.rd = rd[2:0]; t.rw = rw[0]; t.ld = ld[0];
    t.br = br[0]; t.clr = clr[0]; t.es = es[0]; t.ef = ef[0];
    t.efa = efa[1:0]; t.efb = efb[1:0]; t.cc = cc[0]; t.esc = esc; t.efc = efc;
    return t;
  endfunction

  function automatic void av(input int rs, sel, v, ra, rb, rau, rbu, rd, rw, ld,
                             br, clr, es, ef, efa, efb, cc, esc, efc);
    tbl.push_back(mkv(rs, sel, v, ra, rb, rau, rbu, rd, rw, ld,
                      br, clr, es, ef, efa, efb, cc, esc, efc));
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pick(input int s, output logic ost, ofl, output logic [1:0] ofa, ofb,
                      output int osc, ofc);
    case (s)
      0:       begin ost = st0; ofl = fl0; ofa = fa0; ofb = fb0; osc = int'(sc0); ofc = int'(fc0); end
      1:       begin ost = st1; ofl = fl1; ofa = fa1; ofb = fb1; osc = int'(sc1); ofc = int'(fc1); end
      2:       begin ost = st2; ofl = fl2; ofa = fa2; ofb = fb2; osc = int'(sc2); ofc = int'(fc2); end
      default: begin ost = st3; ofl = fl3; ofa = fa3; ofb = fb3; osc = int'(sc3); ofc = int'(fc3); end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_ra = t.ra; id_rb = t.rb; id_ra_used = t.rau; id_rb_used = t.rbu;
    id_rd = t.rd; id_regwrite = t.rw; id_memread = t.ld;
    ex_branch_taken = t.br; cnt_clr = t.clr;
  endtask

  task automatic idle();
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0;
    idle();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    logic ost, ofl;
    logic [1:0] ofa, ofb;
    int osc, ofc;
    if (t.rs) do_reset();
    cyc();
    drive(t);
    sb.push_back(t);
    #3;
    e = sb.pop_front();
    pick(e.sel, ost, ofl, ofa, ofb, osc, ofc);
    check($sformatf("v%0d.stall", idx), int'(ost), int'(e.es));
    check($sformatf("v%0d.flush", idx), int'(ofl), int'(e.ef));
    check($sformatf("v%0d.fwd_a", idx), int'(ofa), int'(e.efa));
    check($sformatf("v%0d.fwd_b", idx), int'(ofb), int'(e.efb));
    if (e.cc) begin
      check($sformatf("v%0d.stall_cnt", idx), osc, e.esc);
      check($sformatf("v%0d.flush_cnt", idx), ofc, e.efc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", nchecks, nerr);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    idle();

    // rs sel | v ra rb rau rbu rd rw ld | br clr | stall flush fa fb | cc scnt fcnt
    // back-to-back ALU dependency, then WB forward on rb
    av(1,0, 1,2,3,1,1,1,1,0, 0,0, 0,0,0,0, 1,0,0);
    av(0,0, 1,1,1,1,1,2,1,0, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 1,4,1,1,1,3,1,0, 0,0, 0,0,1,1, 0,0,0);
    av(0,0, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,2, 0,0,0);
    av(0,0, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,0);
    // MEM has priority over WB; unused rb never forwards
    av(1,0, 1,6,7,1,1,1,1,0, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 1,6,7,1,1,1,1,0, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 1,1,1,1,0,5,1,0, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 0,0,0,0,0,0,0,0, 0,0, 0,0,1,0, 0,0,0);
    // load without regwrite creates no hazard
    av(1,0, 1,0,0,0,0,3,0,1, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 1,3,3,1,1,4,1,0, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,0);
    // load-use: one stall, then MEM/WB forward
    av(1,0, 1,2,0,1,0,3,1,1, 0,0, 0,0,0,0, 1,0,0);
    av(0,0, 1,3,5,1,1,4,1,0, 0,0, 1,0,0,0, 0,0,0);
    av(0,0, 1,3,5,1,1,4,1,0, 0,0, 0,0,0,0, 1,1,0);
    av(0,0, 0,0,0,0,0,0,0,0, 0,0, 0,0,2,0, 1,1,0);
    // taken branch over a load-use: flush wins, EX becomes a bubble
    av(1,0, 1,0,0,0,0,3,1,1, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 1,3,5,1,1,4,1,0, 1,0, 0,1,0,0, 0,0,0);
    av(0,0, 0,0,0,0,0,0,0,0, 1,0, 0,0,0,0, 1,0,1);
    av(0,0, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,1);
    // id_valid=0 never stalls
    av(1,0, 1,0,0,0,0,3,1,1, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 0,3,3,1,1,4,1,0, 0,0, 0,0,0,0, 1,0,0);
    // r0 rule, R0_ZERO=1
    av(1,0, 1,0,0,0,0,0,1,1, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 1,0,0,1,1,1,1,0, 0,0, 0,0,0,0, 0,0,0);
    av(0,0, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,0);
    // r0 rule, R0_ZERO=0
    av(1,1, 1,0,0,0,0,0,1,1, 0,0, 0,0,0,0, 0,0,0);
    av(0,1, 1,0,0,1,1,1,1,0, 0,0, 1,0,0,0, 0,0,0);
    av(0,1, 1,0,0,1,1,1,1,0, 0,0, 0,0,0,0, 1,1,0);
    av(0,1, 0,0,0,0,0,0,0,0, 0,0, 0,0,2,2, 1,1,0);
    // stall-only mode: two stall cycles, no forwarding
    av(1,2, 1,2,3,1,1,1,1,0, 0,0, 0,0,0,0, 0,0,0);
    av(0,2, 1,1,0,1,0,2,1,0, 0,0, 1,0,0,0, 0,0,0);
    av(0,2, 1,1,0,1,0,2,1,0, 0,0, 1,0,0,0, 1,1,0);
    av(0,2, 1,1,0,1,0,2,1,0, 0,0, 0,0,0,0, 1,2,0);
    av(0,2, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 1,2,0);
    // CNTW=2 saturation: five load-use stalls, then clear during a stall
    av(1,3, 1,0,0,0,0,3,1,1, 0,0, 0,0,0,0, 1,0,0);
    for (int k = 1; k <= 10; k++) begin
      av(0,3, 1,3,0,1,0,3,1,1, 0,0, k % 2, 0, ((k % 2) == 1 && k >= 3) ? 2 : 0, 0,
         (k % 2) == 0, (k / 2 > 3) ? 3 : k / 2, 0);
    end
    av(0,3, 1,3,0,1,0,3,1,1, 0,1, 1,0,2,0, 1,3,0);
    av(0,3, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,0);
    av(0,3, 0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 1,0,0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // asynchronous reset in the middle of a stall cycle
    do_reset();
    cyc(); drive(mkv(0,0, 1,0,0,0,0,3,1,1, 0,0, 0,0,0,0, 0,0,0));
    cyc(); drive(mkv(0,0, 1,3,0,1,0,4,1,0, 0,0, 0,0,0,0, 0,0,0));
    #2 check("ar.pre_stall", int'(st0), 1);
    cyc(); drive(mkv(0,0, 1,0,0,0,0,3,1,1, 0,0, 0,0,0,0, 0,0,0));
    cyc(); drive(mkv(0,0, 1,3,0,1,0,4,1,0, 1,0, 0,0,0,0, 0,0,0));
    #2 check("ar.pre_flush", int'(fl0), 1);
    cyc(); drive(mkv(0,0, 1,0,0,0,0,3,1,1, 0,0, 0,0,0,0, 0,0,0));
    cyc(); drive(mkv(0,0, 1,3,0,1,0,4,1,0, 0,0, 0,0,0,0, 0,0,0));
    #1;
    check("ar.stall_before", int'(st0), 1);
    check("ar.scnt_before", int'(sc0), 1);
    check("ar.fcnt_before", int'(fc0), 1);
    #1 rst = 1'b0;
    #1;
    check("ar.stall", int'(st0), 0);
    check("ar.flush", int'(fl0), 0);
    check("ar.fwd_a", int'(fa0), 0);
    check("ar.fwd_b", int'(fb0), 0);
    check("ar.scnt", int'(sc0), 0);
    check("ar.fcnt", int'(fc0), 0);
    check("ar.stall_u2", int'(st2), 0);
    check("ar.scnt_u3", int'(sc3), 0);
    cyc(); rst = 1'b1;
    #2;
    check("ar.post_stall", int'(st0), 0);
    check("ar.post_scnt", int'(sc0), 0);
    cyc(); idle();
    #2;
    check("ar.post_fwd_a", int'(fa0), 0);
    check("ar.post_stall2", int'(st0), 0);
    check("ar.post_scnt2", int'(sc0), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
